rr_arb8_ctrl: RTL and testbench



---
 rtl/rr_arb8_ctrl_pkg.sv | 17 +
 rtl/rr_arb8_ctrl_chk.sv | 19 +
 rtl/rr_arb8_ctrl_pick8.sv | 28 ++
 rtl/rr_arb8_ctrl.sv | 84 ++++++++
 tb/tb_rr_arb8_ctrl.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/rr_arb8_ctrl_pkg.sv
// Shared constants and state encoding for the 8-way round-robin arbiter.
package rr_arb8_ctrl_pkg;

  localparam int NUM_REQ = 8;
  localparam int IDX_W   = 3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  // Next pointer after a release; wraps 7 -> 0 through natural 3-bit overflow.
  function automatic logic [IDX_W-1:0] idx_next(input logic [IDX_W-1:0] idx);
    return idx + 3'd1;
  endfunction

endpackage

// File: rtl/rr_arb8_ctrl_chk.sv
// Invariant checker for rr_arb8_ctrl outputs; attach alongside the arbiter.
module rr_arb8_ctrl_chk
  import rr_arb8_ctrl_pkg::*;
(
  input logic               clk,
  input logic               rst,
  input logic [NUM_REQ-1:0] gnt,
  input logic [IDX_W-1:0]   gnt_idx,
  input logic               gnt_vld,
  input logic               timeout
);

  a_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt));
  a_vld:     assert property (@(posedge clk) disable iff (rst) gnt_vld == (gnt != 8'h00));
  a_idx:     assert property (@(posedge clk) disable iff (rst) gnt_vld |-> (gnt == (8'd1 << gnt_idx)));
  a_to_idle: assert property (@(posedge clk) disable iff (rst) timeout |-> !gnt_vld);
  a_to_once: assert property (@(posedge clk) disable iff (rst) timeout |=> !timeout);

endmodule

// File: rtl/rr_arb8_ctrl_pick8.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping 7 -> 0.
module arb_rr_pick8
  import rr_arb8_ctrl_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   sel,
  output logic               any
);

  logic [2*NUM_REQ-1:0] dbl;
  logic [NUM_REQ-1:0]   rot;
  logic [IDX_W-1:0]     off;

  // Rotate so bit 0 is the highest-priority requester, find the lowest set bit, rotate back.
  always_comb begin
    dbl = {req, req};
    rot = dbl[ptr +: NUM_REQ];
    off = 3'd0;
    any = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      off = rot[k] ? 3'(k) : off;
      any = any | rot[k];
    end
    sel = ptr + off;
  end

endmodule

// File: rtl/rr_arb8_ctrl.sv
// Round-robin grant sequencer for 8 requesters with bounded hold time and one dead cycle between grants.
module rr_arb8_ctrl
  import rr_arb8_ctrl_pkg::*;
#(
  parameter int MAX_HOLD = 15,
  parameter int HOLD_W   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               arb_en,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               gnt_vld,
  output logic               timeout
);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  state_t             state;
  logic [IDX_W-1:0]   ptr;
  logic [HOLD_W-1:0]  hold_cnt;
  logic [IDX_W-1:0]   sel;
  logic               any;

  arb_rr_pick8 u_pick (
    .req (req),
    .ptr (ptr),
    .sel (sel),
    .any (any)
  );

  // Arbitration FSM with registered grant, index, valid and timeout outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      ptr      <= 3'd0;
      hold_cnt <= '0;
      gnt      <= 8'h00;
      gnt_idx  <= 3'd0;
      gnt_vld  <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          timeout <= 1'b0;
          if (arb_en && any) begin
            state    <= ST_BUSY;
            gnt      <= 8'd1 << sel;
            gnt_idx  <= sel;
            gnt_vld  <= 1'b1;
            hold_cnt <= '0;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_BUSY: begin
          // The releasing owner drops to lowest priority next round.
          if (!req[gnt_idx]) begin
            state   <= ST_IDLE;
            gnt     <= 8'h00;
            gnt_vld <= 1'b0;
            ptr     <= idx_next(gnt_idx);
          end else if (hold_cnt == HOLD_LAST) begin
            state   <= ST_IDLE;
            gnt     <= 8'h00;
            gnt_vld <= 1'b0;
            timeout <= 1'b1;
            ptr     <= idx_next(gnt_idx);
          end else begin
            hold_cnt <= hold_cnt + {{(HOLD_W-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          state   <= ST_IDLE;
          gnt     <= 8'h00;
          gnt_vld <= 1'b0;
          timeout <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arb8_ctrl.sv
// Directed bench for rr_arb8_ctrl: a tenure-level reference model checked every cycle plus literal checkpoints.
module tb_rr_arb8_ctrl;

  localparam int MAX_HOLD = 15;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       arb_en = 1'b1;
  logic [7:0] req = 8'h00;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_vld;
  logic       timeout;

  int errors = 0;
  int checks = 0;
  bit chk_on = 1'b0;

  // Reference model: owner is -1 when idle, tenure counts cycles the owner has held the grant.
  int m_owner = -1;
  int m_last  = 0;
  int m_ptr   = 0;
  int m_ten   = 0;
  bit m_to    = 1'b0;

  always #5 clk = ~clk;

  rr_arb8_ctrl #(.MAX_HOLD(MAX_HOLD), .HOLD_W(4)) dut (
    .clk(clk), .rst(rst), .arb_en(arb_en), .req(req),
    .gnt(gnt), .gnt_idx(gnt_idx), .gnt_vld(gnt_vld), .timeout(timeout)
  );

  rr_arb8_ctrl_chk chk (
    .clk(clk), .rst(rst), .gnt(gnt), .gnt_idx(gnt_idx), .gnt_vld(gnt_vld), .timeout(timeout)
  );

  always @(posedge clk) begin
    int c;
    if (rst) begin
      m_owner = -1; m_last = 0; m_ptr = 0; m_ten = 0; m_to = 1'b0;
    end else if (m_owner < 0) begin
      m_to = 1'b0;
      c = -1;
      if (arb_en) begin
        for (int k = 0; k < 8; k++)
          if (c < 0 && req[(m_ptr + k) % 8]) c = (m_ptr + k) % 8;
      end
      if (c >= 0) begin
        m_owner = c; m_last = c; m_ten = 1;
      end
    end else if (!req[m_owner]) begin
      m_ptr = (m_owner + 1) % 8; m_owner = -1;
    end else if (m_ten == MAX_HOLD) begin
      m_ptr = (m_owner + 1) % 8; m_owner = -1; m_to = 1'b1;
    end else begin
      m_ten = m_ten + 1;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    logic [7:0] eg;
    if (chk_on) begin
      eg = (m_owner < 0) ? 8'h00 : (8'h01 << m_owner);
      checks++;
      if (gnt !== eg || gnt_idx !== 3'(m_last) || gnt_vld !== (m_owner >= 0) || timeout !== m_to) begin
        errors++;
        $display("FAIL model t=%0t: gnt=%h idx=%0d vld=%b to=%b, want gnt=%h idx=%0d vld=%b to=%b",
                 $time, gnt, gnt_idx, gnt_vld, timeout, eg, m_last, (m_owner >= 0), m_to);
      end
    end
  end

  task automatic lit(input string name, input logic [7:0] g, input logic [2:0] i,
                     input logic v, input logic t);
    checks++;
    if (gnt !== g || gnt_idx !== i || gnt_vld !== v || timeout !== t) begin
      errors++;
      $display("FAIL %s: gnt=%h idx=%0d vld=%b to=%b, want gnt=%h idx=%0d vld=%b to=%b",
               name, gnt, gnt_idx, gnt_vld, timeout, g, i, v, t);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [7:0] one;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_on = 1'b1;

    // Idle after reset.
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      lit("idle", 8'h00, 3'd0, 1'b0, 1'b0);
    end

    // Two requesters, first owner releases after three cycles.
    req = 8'h24;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      lit("grant2", 8'h04, 3'd2, 1'b1, 1'b0);
    end
    req = 8'h20;
    @(negedge clk);
    lit("dead2", 8'h00, 3'd2, 1'b0, 1'b0);
    @(negedge clk);
    lit("grant5", 8'h20, 3'd5, 1'b1, 1'b0);
    req = 8'h00;
    @(negedge clk);
    lit("rel5", 8'h00, 3'd5, 1'b0, 1'b0);

    // All requesting: rotation 0..7,0 with one dead cycle per hand-over.
    do_reset();
    req = 8'hFF;
    for (int g = 0; g < 9; g++) begin
      one = 8'h01 << (g % 8);
      @(negedge clk);
      lit("rot_g1", one, 3'(g % 8), 1'b1, 1'b0);
      @(negedge clk);
      lit("rot_g2", one, 3'(g % 8), 1'b1, 1'b0);
      req = 8'hFF & ~one;
      @(negedge clk);
      lit("rot_dead", 8'h00, 3'(g % 8), 1'b0, 1'b0);
      req = 8'hFF;
    end
    req = 8'h00;
    @(negedge clk);
    @(negedge clk);

    // Forced release after MAX_HOLD cycles, then immediate re-grant.
    do_reset();
    req = 8'h08;
    for (int n = 0; n < MAX_HOLD; n++) begin
      @(negedge clk);
      lit("hold", 8'h08, 3'd3, 1'b1, 1'b0);
    end
    @(negedge clk);
    lit("timeout", 8'h00, 3'd3, 1'b0, 1'b1);
    @(negedge clk);
    lit("regrant", 8'h08, 3'd3, 1'b1, 1'b0);
    req = 8'h00;
    @(negedge clk);
    lit("rel3", 8'h00, 3'd3, 1'b0, 1'b0);

    // arb_en gating only affects new grants.
    do_reset();
    arb_en = 1'b0;
    req = 8'h81;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      lit("en_off", 8'h00, 3'd0, 1'b0, 1'b0);
    end
    arb_en = 1'b1;
    @(negedge clk);
    lit("en_on", 8'h01, 3'd0, 1'b1, 1'b0);
    arb_en = 1'b0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      lit("en_busy", 8'h01, 3'd0, 1'b1, 1'b0);
    end
    req = 8'h80;
    @(negedge clk);
    lit("en_rel", 8'h00, 3'd0, 1'b0, 1'b0);
    @(negedge clk);
    lit("en_block", 8'h00, 3'd0, 1'b0, 1'b0);
    arb_en = 1'b1;
    @(negedge clk);
    lit("en_grant7", 8'h80, 3'd7, 1'b1, 1'b0);
    req = 8'h00;
    @(negedge clk);

    // Reset mid-grant discards the tenure and restarts from pointer 0.
    do_reset();
    req = 8'h40;
    @(negedge clk);
    lit("g6", 8'h40, 3'd6, 1'b1, 1'b0);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    req = 8'h41;
    @(negedge clk);
    lit("rst_mid", 8'h00, 3'd0, 1'b0, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    lit("post_rst", 8'h01, 3'd0, 1'b1, 1'b0);
    req = 8'h40;
    @(negedge clk);
    lit("post_rel", 8'h00, 3'd0, 1'b0, 1'b0);
    @(negedge clk);
    lit("post_g6", 8'h40, 3'd6, 1'b1, 1'b0);
    req = 8'h00;
    repeat (3) @(negedge clk);

    chk_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
